ov7670_pixel_capture: RTL and testbench
=======================================

# ov7670_pixel_capture

- Parametrised OV7670 DVP capture front end.
- Samples the camera byte bus on PCLK, tracks frame and line framing from VSYNC/HREF with explicit edge detection, and packs bytes into pixels.
- Pixel formats: RGB444 (xR GB), RGB565, RGB555 or RAW8 Bayer; the format is selected per frame.
- Emits one valid-qualified pixel with x/y coordinates and start-of-frame/end-of-line markers, feeding the demosaic and framebuffer write path.

## Interface
Parameters:
- MAX_WIDTH, 640: pixels per line before the x counter saturates.
- MAX_HEIGHT, 480: lines per frame before the y counter saturates.
- X_W, $clog2(MAX_WIDTH): width of o_X.
- Y_W, $clog2(MAX_HEIGHT): width of o_Y.

Ports:
- PCLK  in  1  camera pixel clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- D  in  8  camera data bus.
- HREF  in  1  line-active strobe from the camera.
- VSYNC  in  1  frame sync; high marks vertical blanking.
- MODE  in  2  format select: 0 RGB444, 1 RGB565, 2 RGB555, 3 RAW8.
- o_PIXEL  out  16  packed pixel, right-justified, zero-filled upper bits.
- o_VALID  out  1  o_PIXEL, o_X and o_Y are valid this cycle.
- o_SOF  out  1  first pixel of a frame (x=0, y=0); qualified by o_VALID.
- o_EOL  out  1  single-cycle pulse after each line ends.
- o_X  out  X_W  pixel column.
- o_Y  out  Y_W  line row.
- o_ERR  out  1  single-cycle pulse on a framing error.

## Operation
- **Input stage.** D, HREF and VSYNC are registered once on posedge PCLK (d_q, href_q, vsync_q). A second register on HREF/VSYNC provides rise and fall detection. All FSM decisions use the registered values.
- **Mode latch.** MODE is latched on VSYNC fall (frame start) and held for the whole frame. Changing MODE mid-frame has no effect until the next frame.
- **FSM states:**
  - WAIT_FRAME: reset state. Advance to LINE_IDLE on VSYNC fall.
  - LINE_IDLE: HREF low. On HREF rise: go to BYTE0, clear x.
  - BYTE0: capture the first byte. RAW8 emits a pixel immediately and stays in BYTE0; other modes go to BYTE1.
  - BYTE1: combine with the held byte, emit a pixel, go to BYTE0.
  - From BYTE0 or BYTE1, HREF fall returns to LINE_IDLE, pulses o_EOL and increments y (saturating at MAX_HEIGHT-1).
  - From any state, VSYNC rise returns to WAIT_FRAME.
- **Packing** (b0 = first byte, b1 = second byte):
  - RGB444: {4'h0, b0[3:0], b1}.
  - RGB565: {b0, b1}.
  - RGB555: {1'b0, b0[6:0], b1}.
  - RAW8: {8'h00, b0}.
- **Coordinates.** x increments after each emitted pixel and saturates at MAX_WIDTH-1. y is cleared at frame start.
- **o_ERR pulses on:**
  - HREF fall while in BYTE1: odd byte count. The partial pixel is dropped.
  - VSYNC rise while HREF is high: frame aborted. The partial pixel is dropped.
  - x or y reaching saturation and a further pixel or line arriving. That data is still emitted, using the saturated coordinate.
- **Simultaneous events.** VSYNC rise takes priority over HREF edges. An HREF fall in the same cycle as a byte completion emits that pixel, then pulses o_EOL one cycle later.
- **Reset (including mid-line).**
  - All outputs go to 0 and the FSM goes to WAIT_FRAME.
  - After reset the block ignores data until a full VSYNC high→low transition is seen, so no partial frame is captured.

## Timing
- Latency: a byte present on D at posedge n completes a pixel; o_VALID is high in the cycle after posedge n+1. That is 2 cycles for every mode.
- o_VALID is single-cycle per pixel:
  - RGB modes: at most every other cycle.
  - RAW8: every cycle.
- o_EOL asserts 2 cycles after the PCLK edge at which HREF is first sampled low.
- o_SOF coincides with the first o_VALID of a frame only.
- Outputs are registered and hold their last value when o_VALID is low. Only o_VALID, o_SOF, o_EOL and o_ERR pulse.

## Structure
- Package ov7670_pkg holds:
  - the mode_t enum {MODE_RGB444, MODE_RGB565, MODE_RGB555, MODE_RAW8};
  - the state_t enum {WAIT_FRAME, LINE_IDLE, BYTE0, BYTE1};
  - a pure function pack_pixel(mode_t, b0, b1) returning the 16-bit pixel.
- Sub-module ov7670_sync_edge:
  - registers HREF and VSYNC with RST_N;
  - outputs level, rise and fall for each;
  - shared with later camera blocks.

## Test plan
- RGB444, 4-pixel line with bytes 0x0A,0xBC,0x01,0x23,… → o_PIXEL 0x0ABC then 0x0123, x = 0..3, y = 0, o_SOF on the first pixel only, o_EOL once.
- RGB565, bytes 0xF8,0x00 → 0xF800. Same line in RGB555 with bytes 0xFC,0x00 → 0x7C00. MODE switched mid-frame applies from the next frame.
- RAW8, 8 consecutive bytes 0x10..0x17 → 8 back-to-back o_VALID, pixels 0x0010..0x0017, x = 0..7.
- Odd byte count: 3 bytes in RGB565 → one pixel, o_ERR pulse, o_EOL pulse, no second pixel.
- VSYNC rises mid-line → o_ERR pulse, no further o_VALID until the next VSYNC fall; the next frame restarts at y = 0.
- RST_N asserted mid-line → all outputs 0 immediately. After release, data ignored until a VSYNC high→low, then normal capture from x = 0, y = 0.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and pixel packing for the OV7670 DVP capture path.
package ov7670_pkg;

  typedef enum logic [1:0] {
    MODE_RGB444,
    MODE_RGB565,
    MODE_RGB555,
    MODE_RAW8
  } mode_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    LINE_IDLE,
    BYTE0,
    BYTE1
  } state_t;

  // b0 is the first byte of the pixel on the bus, b1 the second.
  function automatic logic [15:0] pack_pixel(input mode_t mode, input logic [7:0] b0,
                                             input logic [7:0] b1);
    case (mode)
      MODE_RGB444: return {4'h0, b0[3:0], b1};
      MODE_RGB565: return {b0, b1};
      MODE_RGB555: return {1'b0, b0[6:0], b1};
      default:     return {8'h00, b0};
    endcase
  endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers the camera HREF/VSYNC strobes and derives rise/fall pulses from a second stage.
module ov7670_sync_edge (
  input  logic PCLK,
  input  logic RST_N,
  input  logic HREF,
  input  logic VSYNC,
  output logic href_q,
  output logic href_rise,
  output logic href_fall,
  output logic vsync_q,
  output logic vsync_rise,
  output logic vsync_fall
);

  logic href_q2;
  logic vsync_q2;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      href_q   <= 1'b0;
      href_q2  <= 1'b0;
      vsync_q  <= 1'b0;
      vsync_q2 <= 1'b0;
    end else begin
      href_q   <= HREF;
      href_q2  <= href_q;
      vsync_q  <= VSYNC;
      vsync_q2 <= vsync_q;
    end
  end

  assign href_rise  = href_q & ~href_q2;
  assign href_fall  = ~href_q & href_q2;
  assign vsync_rise = vsync_q & ~vsync_q2;
  assign vsync_fall = ~vsync_q & vsync_q2;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 DVP capture: frames/lines from VSYNC/HREF, packs bytes into pixels with x/y coordinates.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int X_W        = $clog2(MAX_WIDTH),
  parameter int Y_W        = $clog2(MAX_HEIGHT)
) (
  input  logic           PCLK,
  input  logic           RST_N,
  input  logic [7:0]     D,
  input  logic           HREF,
  input  logic           VSYNC,
  input  logic [1:0]     MODE,
  output logic [15:0]    o_PIXEL,
  output logic           o_VALID,
  output logic           o_SOF,
  output logic           o_EOL,
  output logic [X_W-1:0] o_X,
  output logic [Y_W-1:0] o_Y,
  output logic           o_ERR
);

  localparam logic [X_W-1:0] X_MAX = X_W'(MAX_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAX_HEIGHT - 1);

  logic       href_q, href_rise, href_fall;
  logic       vsync_q, vsync_rise, vsync_fall;
  logic [7:0] d_q;

  state_t         state;
  mode_t          mode_q;
  logic [7:0]     b0_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           x_full;
  logic           y_full;
  logic           sof_pend;

  logic           line_start;
  logic           in_line;
  logic           emit;
  logic [15:0]    emit_pix;
  logic [X_W-1:0] x_cur;
  logic           x_full_cur;

  ov7670_sync_edge u_sync (
    .PCLK       (PCLK),
    .RST_N      (RST_N),
    .HREF       (HREF),
    .VSYNC      (VSYNC),
    .href_q     (href_q),
    .href_rise  (href_rise),
    .href_fall  (href_fall),
    .vsync_q    (vsync_q),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall)
  );

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) d_q <= 8'h00;
    else        d_q <= D;
  end

  // The byte arriving with the HREF rise is the first byte of the line, so the rise cycle
  // itself consumes data exactly like BYTE0 does.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    line_start = 1'b0;
    in_line    = 1'b0;
    emit       = 1'b0;
    emit_pix   = 16'h0000;
    line_start = (state == LINE_IDLE) && href_rise && !vsync_q;
    in_line    = ((state == BYTE0) || (state == BYTE1)) && href_q;
    x_cur      = line_start ? '0 : x_q;
    x_full_cur = line_start ? 1'b0 : x_full;
    if ((line_start || (in_line && state == BYTE0)) && mode_q == MODE_RAW8) begin
      emit     = 1'b1;
      emit_pix = pack_pixel(mode_q, d_q, 8'h00);
    end else if (in_line && state == BYTE1) begin
      emit     = 1'b1;
      emit_pix = pack_pixel(mode_q, b0_q, d_q);
    end
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= WAIT_FRAME;
      mode_q   <= MODE_RGB444;
      b0_q     <= 8'h00;
      x_q      <= '0;
      y_q      <= '0;
      x_full   <= 1'b0;
      y_full   <= 1'b0;
      sof_pend <= 1'b0;
      o_PIXEL  <= 16'h0000;
      o_VALID  <= 1'b0;
      o_SOF    <= 1'b0;
      o_EOL    <= 1'b0;
      o_X      <= '0;
      o_Y      <= '0;
      o_ERR    <= 1'b0;
    end else begin
      o_VALID <= 1'b0;
      o_SOF   <= 1'b0;
      o_EOL   <= 1'b0;
      o_ERR   <= 1'b0;
      if (vsync_rise) begin
        // Frame abort wins over any HREF edge; a held half-pixel is simply discarded.
        state <= WAIT_FRAME;
        o_ERR <= href_q && (state != WAIT_FRAME);
      end else begin
        case (state)
          WAIT_FRAME: begin
            if (vsync_fall) begin
              state    <= LINE_IDLE;
              mode_q   <= mode_t'(MODE);
              y_q      <= '0;
              y_full   <= 1'b0;
              sof_pend <= 1'b1;
            end
          end
          LINE_IDLE: begin
            if (line_start) begin
              state  <= (mode_q == MODE_RAW8) ? BYTE0 : BYTE1;
              b0_q   <= d_q;
              x_q    <= '0;
              x_full <= 1'b0;
              if (y_full) o_ERR <= 1'b1;
            end
          end
          BYTE0, BYTE1: begin
            if (href_fall) begin
              state <= LINE_IDLE;
              o_EOL <= 1'b1;
              if (state == BYTE1) o_ERR <= 1'b1;
              if (y_q == Y_MAX) y_full <= 1'b1;
              else              y_q    <= y_q + 1'b1;
            end else if (state == BYTE1) begin
              state <= BYTE0;
            end else if (mode_q != MODE_RAW8) begin
              b0_q  <= d_q;
              state <= BYTE1;
            end
          end
          default: state <= WAIT_FRAME;
        endcase

        if (emit) begin
          o_VALID  <= 1'b1;
          o_PIXEL  <= emit_pix;
          o_X      <= x_cur;
          o_Y      <= y_q;
          o_SOF    <= sof_pend;
          sof_pend <= 1'b0;
          if (x_full_cur) o_ERR <= 1'b1;
          if (x_cur == X_MAX) x_full <= 1'b1;
          else                x_q    <= x_cur + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture: scoreboard of expected pixels plus framing sequences.
module tb_ov7670_pixel_capture;

  localparam int MW = 8;
  localparam int MH = 4;
  localparam int XW = $clog2(MW);
  localparam int YW = $clog2(MH);

  logic          PCLK  = 1'b0;
  logic          RST_N = 1'b1;
  logic [7:0]    D     = 8'h00;
  logic          HREF  = 1'b0;
  logic          VSYNC = 1'b0;
  logic [1:0]    MODE  = 2'd0;
  logic [15:0]   o_PIXEL;
  logic          o_VALID, o_SOF, o_EOL, o_ERR;
  logic [XW-1:0] o_X;
  logic [YW-1:0] o_Y;

  ov7670_pixel_capture #(.MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
    .PCLK    (PCLK),
    .RST_N   (RST_N),
    .D       (D),
    .HREF    (HREF),
    .VSYNC   (VSYNC),
    .MODE    (MODE),
    .o_PIXEL (o_PIXEL),
    .o_VALID (o_VALID),
    .o_SOF   (o_SOF),
    .o_EOL   (o_EOL),
    .o_X     (o_X),
    .o_Y     (o_Y),
    .o_ERR   (o_ERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [15:0]   pix;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] pix;
  } vec_t;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] pq_t[$];

  exp_t exp_q[$];
  exp_t mon_e;
  bq_t  bq;
  pq_t  pq;
  vec_t vecs[9];

  int total = 0, bad = 0;
  int eol_cnt = 0, err_cnt = 0, run_len = 0, max_run = 0;
  int e0 = 0, r0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected pixel per o_VALID and counts the pulse outputs.
  always @(negedge PCLK) begin
    if (RST_N) begin
      if (o_EOL) eol_cnt++;
      if (o_ERR) err_cnt++;
      if (o_VALID) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", o_VALID, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", o_PIXEL, mon_e.pix);
          check("x", o_X, mon_e.x);
          check("y", o_Y, mon_e.y);
          check("sof", o_SOF, mon_e.sof);
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic tick(input logic [7:0] d, input logic h, input logic v);
    D = d; HREF = h; VSYNC = v;
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(8'h00, 1'b0, VSYNC);
  endtask

  task automatic start_frame(input logic [1:0] m);
    MODE = m;
    repeat (3) tick(8'h00, 1'b0, 1'b1);
    repeat (3) tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [15:0] pix, input int x, input int y, input logic sof);
    exp_t e;
    e.pix = pix;
    e.x   = XW'(x);
    e.y   = YW'(y);
    e.sof = sof;
    exp_q.push_back(e);
  endtask

  task automatic run_line(input bq_t bytes, input pq_t pix, input int y, input logic sof,
                          input int tail);
    foreach (pix[i]) push_exp(pix[i], (i > MW - 1) ? MW - 1 : i, y, sof && (i == 0));
    foreach (bytes[i]) tick(bytes[i], 1'b1, 1'b0);
    idle(tail);
  endtask

  task automatic snap();
    e0 = eol_cnt;
    r0 = err_cnt;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, o_VALID, 0);
    check({tag, "_pixel"}, o_PIXEL, 0);
    check({tag, "_x"}, o_X, 0);
    check({tag, "_y"}, o_Y, 0);
    check({tag, "_sof"}, o_SOF, 0);
    check({tag, "_eol"}, o_EOL, 0);
    check({tag, "_err"}, o_ERR, 0);
  endtask

  initial begin
    vecs[0] = '{2'd1, 8'hF8, 8'h00, 16'hF800};
    vecs[1] = '{2'd2, 8'hFC, 8'h00, 16'h7C00};
    vecs[2] = '{2'd0, 8'hFF, 8'hFF, 16'h0FFF};
    vecs[3] = '{2'd1, 8'h12, 8'h34, 16'h1234};
    vecs[4] = '{2'd2, 8'hFF, 8'hFF, 16'h7FFF};
    vecs[5] = '{2'd0, 8'hA5, 8'h5A, 16'h055A};
    vecs[6] = '{2'd3, 8'h9C, 8'h00, 16'h009C};
    vecs[7] = '{2'd2, 8'h80, 8'h01, 16'h0001};
    vecs[8] = '{2'd3, 8'hFF, 8'h00, 16'h00FF};

    #2 RST_N = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check_outputs_zero("reset");
    RST_N = 1'b1;

    // Data before any VSYNC fall must be ignored.
    snap();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    pq.delete();
    run_line(bq, pq, 0, 1'b0, 4);
    check("pre_frame_eol", eol_cnt - e0, 0);

    // RGB444 four-pixel line with exact EOL timing.
    start_frame(2'd0);
    snap();
    bq = '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    pq = '{16'h0ABC, 16'h0123, 16'h0567, 16'h09AB};
    run_line(bq, pq, 0, 1'b1, 0);
    tick(8'h00, 1'b0, 1'b0);
    check("last_pixel_valid", o_VALID, 1);
    check("eol_not_yet", o_EOL, 0);
    tick(8'h00, 1'b0, 1'b0);
    check("eol_pulse", o_EOL, 1);
    tick(8'h00, 1'b0, 1'b0);
    check("eol_single", o_EOL, 0);
    idle(2);
    check("rgb444_eol_count", eol_cnt - e0, 1);
    check("rgb444_err_count", err_cnt - r0, 0);

    // One-pixel frames across modes.
    for (int i = 0; i < 9; i++) begin
      start_frame(vecs[i].mode);
      if (vecs[i].mode == 2'd3) bq = '{vecs[i].b0};
      else                      bq = '{vecs[i].b0, vecs[i].b1};
      pq = '{vecs[i].pix};
      run_line(bq, pq, 0, 1'b1, 4);
    end

    // MODE change mid-frame only applies to the next frame.
    start_frame(2'd1);
    bq = '{8'hF8, 8'h00}; pq = '{16'hF800};
    run_line(bq, pq, 0, 1'b1, 4);
    MODE = 2'd2;
    bq = '{8'hFC, 8'h00}; pq = '{16'hFC00};
    run_line(bq, pq, 1, 1'b0, 4);
    start_frame(2'd2);
    bq = '{8'hFC, 8'h00}; pq = '{16'h7C00};
    run_line(bq, pq, 0, 1'b1, 4);

    // RAW8: back-to-back pixels, two-cycle latency, then x saturation.
    start_frame(2'd3);
    snap();
    for (int i = 0; i < 8; i++) push_exp(16'h0010 + 16'(i), i, 0, i == 0);
    max_run = 0;
    tick(8'h10, 1'b1, 1'b0);
    check("raw8_latency_early", o_VALID, 0);
    tick(8'h11, 1'b1, 1'b0);
    check("raw8_latency_on", o_VALID, 1);
    for (int i = 2; i < 8; i++) tick(8'h10 + 8'(i), 1'b1, 1'b0);
    idle(4);
    check("raw8_back_to_back", max_run, 8);
    check("raw8_err_count", err_cnt - r0, 0);
    snap();
    bq.delete(); pq.delete();
    for (int i = 0; i < 9; i++) begin
      bq.push_back(8'h20 + 8'(i));
      pq.push_back(16'h0020 + 16'(i));
    end
    run_line(bq, pq, 1, 1'b0, 4);
    check("x_sat_err", err_cnt - r0, 1);

    // Odd byte count in RGB565.
    start_frame(2'd1);
    snap();
    bq = '{8'h11, 8'h22, 8'h33}; pq = '{16'h1122};
    run_line(bq, pq, 0, 1'b1, 4);
    check("odd_err", err_cnt - r0, 1);
    check("odd_eol", eol_cnt - e0, 1);

    // y saturation: fifth line reuses the last row and flags an error.
    start_frame(2'd1);
    snap();
    for (int l = 0; l < 5; l++) begin
      bq = '{8'hA1, 8'hB2}; pq = '{16'hA1B2};
      run_line(bq, pq, (l > MH - 1) ? MH - 1 : l, l == 0, 4);
    end
    check("y_sat_err", err_cnt - r0, 1);
    check("y_sat_eol", eol_cnt - e0, 5);

    // VSYNC rises mid-line: abort, drop partial pixel, next frame restarts at y=0.
    start_frame(2'd1);
    bq = '{8'h11, 8'h22}; pq = '{16'h1122};
    run_line(bq, pq, 0, 1'b1, 4);
    snap();
    push_exp(16'hAABB, 0, 1, 1'b0);
    tick(8'hAA, 1'b1, 1'b0);
    tick(8'hBB, 1'b1, 1'b0);
    tick(8'hCC, 1'b1, 1'b0);
    tick(8'hDD, 1'b1, 1'b1);
    tick(8'hEE, 1'b1, 1'b1);
    tick(8'hFF, 1'b1, 1'b1);
    idle(4);
    check("abort_err", err_cnt - r0, 1);
    check("abort_eol", eol_cnt - e0, 0);
    start_frame(2'd1);
    bq = '{8'h12, 8'h34}; pq = '{16'h1234};
    run_line(bq, pq, 0, 1'b1, 4);

    // Reset mid-line: outputs clear at once, data ignored until a VSYNC high->low.
    start_frame(2'd1);
    push_exp(16'h1234, 0, 0, 1'b1);
    tick(8'h12, 1'b1, 1'b0);
    tick(8'h34, 1'b1, 1'b0);
    tick(8'h56, 1'b1, 1'b0);
    #5;
    check("pre_reset_pixel", o_PIXEL, 16'h1234);
    RST_N = 1'b0;
    #1;
    check_outputs_zero("midline_reset");
    tick(8'h78, 1'b1, 1'b0);
    RST_N = 1'b1;
    snap();
    tick(8'h9A, 1'b1, 1'b0);
    tick(8'hBC, 1'b1, 1'b0);
    idle(3);
    bq = '{8'h01, 8'h02}; pq.delete();
    run_line(bq, pq, 0, 1'b0, 4);
    check("post_reset_eol", eol_cnt - e0, 0);
    check("post_reset_err", err_cnt - r0, 0);
    start_frame(2'd1);
    bq = '{8'h9A, 8'hBC}; pq = '{16'h9ABC};
    run_line(bq, pq, 0, 1'b1, 4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
